// File: rtl/multi_matmul_drain.sv
// multi_matmul_drain
//   Consumer-side end of the multi-matmul array output bus. When the array's
//   acc_done flag rises, the concatenated result vector is captured and then
//   streamed out one module slice at a time (module 0 first) on a valid/ready
//   interface toward writeback/softmax logic. Data passes bit-exact.
//
//   Handshake: a slice transfers on every cycle where out_valid & out_ready.
//   While out_valid=1 and out_ready=0, out_data/out_idx/out_last hold stable,
//   and out_valid never drops until the slice is taken.
//
//   Optional feature (macro MULTI_MATMUL_DRAIN_DOUBLE_BUF_EN):
//     adds one pending buffer so a result arriving mid-drain can be held and
//     streamed immediately after the current one. Undefined: single buffer.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   acc_done     in   level flag; a 0->1 transition marks new results
//   in_data      in   SLICE_W*TOTAL_MODULES concatenated results
//   out_ready    in   downstream accepts current slice
//   clr_overrun  in   synchronous clear of overrun
//   out_valid    out  out_data is valid
//   out_data     out  current module slice
//   out_idx      out  module index of out_data
//   out_last     out  final slice of the current result
//   busy         out  a result is held or being drained
//   overrun      out  sticky: a result was dropped
//   dbg_state    out  FSM state (0 = IDLE, 1 = DRAIN)
module multi_matmul_drain #(
    parameter int WIDTH_OUT     = 16,
    parameter int CHUNK_SIZE    = 4,
    parameter int NUM_CORES_A   = 4,
    parameter int NUM_CORES_B   = 1,
    parameter int TOTAL_MODULES = 2,
    localparam int SLICE_W      = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
    localparam int IDX_W        = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               acc_done,
    input  logic [SLICE_W*TOTAL_MODULES-1:0]   in_data,
    input  logic                               out_ready,
    input  logic                               clr_overrun,
    output logic                               out_valid,
    output logic [SLICE_W-1:0]                 out_data,
    output logic [IDX_W-1:0]                   out_idx,
    output logic                               out_last,
    output logic                               busy,
    output logic                               overrun,
    output logic                               dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_MODULES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               acc_done_q;
    logic [SLICE_W-1:0] act_buf [TOTAL_MODULES];
    logic [IDX_W-1:0]   idx_q;
    logic               overrun_q;
    logic               pend_full;

    logic rise, hs, final_hs, draining;
    logic take_new;   // load active buffer straight from in_data
    logic take_pend;  // move pending buffer into active buffer
    logic fill_pend;  // load pending buffer from in_data
    logic drop;       // new result has nowhere to go

    assign draining = (state_q == ST_DRAIN);
    assign rise     = acc_done & ~acc_done_q;
    assign hs       = draining & out_ready;
    assign final_hs = hs & (idx_q == LAST_IDX);

    // Buffer-control decisions. A final handshake frees the active buffer in
    // the same cycle, so a coincident rise is never treated as a drop.
    always_comb begin
        take_new  = 1'b0;
        take_pend = 1'b0;
        fill_pend = 1'b0;
        drop      = 1'b0;
        if (!draining) begin
            take_new = rise;
        end else if (final_hs) begin
            take_pend = pend_full;
            take_new  = rise & ~pend_full;
            fill_pend = rise & pend_full;
        end else if (rise) begin
`ifdef MULTI_MATMUL_DRAIN_DOUBLE_BUF_EN
            fill_pend = ~pend_full;
            drop      = pend_full;
`else
            drop      = 1'b1;
`endif
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rise) state_d = ST_DRAIN;
            ST_DRAIN: if (final_hs && !take_new && !take_pend) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_valid = draining;
        out_data  = draining ? act_buf[idx_q] : '0;
        out_idx   = draining ? idx_q : '0;
        out_last  = draining & (idx_q == LAST_IDX);
        busy      = draining | pend_full;
        overrun   = overrun_q;
        dbg_state = state_q;
    end

`ifdef MULTI_MATMUL_DRAIN_DOUBLE_BUF_EN
    logic [SLICE_W-1:0] pend_buf [TOTAL_MODULES];
    logic               pend_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full_q <= 1'b0;
            for (int i = 0; i < TOTAL_MODULES; i++) pend_buf[i] <= '0;
        end else begin
            if (fill_pend) begin
                for (int i = 0; i < TOTAL_MODULES; i++)
                    pend_buf[i] <= in_data[i*SLICE_W +: SLICE_W];
                pend_full_q <= 1'b1;
            end else if (take_pend) begin
                pend_full_q <= 1'b0;
            end
        end
    end
    assign pend_full = pend_full_q;
`else
    assign pend_full = 1'b0;
`endif

    // Datapath: acc_done delay, active buffer, slice index, overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_done_q <= 1'b0;
            idx_q      <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < TOTAL_MODULES; i++) act_buf[i] <= '0;
        end else begin
            acc_done_q <= acc_done;
            if (take_new) begin
                for (int i = 0; i < TOTAL_MODULES; i++)
                    act_buf[i] <= in_data[i*SLICE_W +: SLICE_W];
                idx_q <= '0;
            end else if (take_pend) begin
`ifdef MULTI_MATMUL_DRAIN_DOUBLE_BUF_EN
                for (int i = 0; i < TOTAL_MODULES; i++)
                    act_buf[i] <= pend_buf[i];
`endif
                idx_q <= '0;
            end else if (hs && !final_hs) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            // A drop in the same cycle as a clear wins.
            if (drop)             overrun_q <= 1'b1;
            else if (clr_overrun) overrun_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_matmul_drain.sv
// Testbench for multi_matmul_drain. A transaction-level reference model keeps
// the slices still owed downstream in a queue; the number of results held is
// derived from the queue length and compared to the buffer capacity.
module tb_multi_matmul_drain;

  localparam int SLICE_W = 256;
  localparam int TM      = 2;
  localparam int VEC_W   = SLICE_W * TM;
  localparam int IDX_W   = 1;
`ifdef MULTI_MATMUL_DRAIN_DOUBLE_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               acc_done = 1'b0;
  logic [VEC_W-1:0]   in_data = '0;
  logic               out_ready = 1'b0;
  logic               clr_overrun = 1'b0;
  logic               out_valid;
  logic [SLICE_W-1:0] out_data;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic               busy;
  logic               overrun;
  logic               dbg_state;

  multi_matmul_drain dut (
    .clk(clk), .rst_n(rst_n), .acc_done(acc_done), .in_data(in_data),
    .out_ready(out_ready), .clr_overrun(clr_overrun), .out_valid(out_valid),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [SLICE_W-1:0] exp_q[$];
  logic m_overrun = 1'b0;
  logic m_acc_q   = 1'b0;
  int   n_checks  = 0;
  int   n_fails   = 0;

  task automatic check(string tag, logic [SLICE_W-1:0] got, logic [SLICE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Compare outputs against the model, advance the model with the current
  // inputs, then move to 1 time unit after the next rising edge.
  task automatic cycle();
    bit mv, rise, drop;
    int rem, held;
    mv = (exp_q.size() > 0);
    check("out_valid", SLICE_W'(out_valid), SLICE_W'(mv));
    check("busy", SLICE_W'(busy), SLICE_W'(mv));
    check("overrun", SLICE_W'(overrun), SLICE_W'(m_overrun));
    check("dbg_state", SLICE_W'(dbg_state), SLICE_W'(mv));
    if (mv) begin
      rem = ((exp_q.size() - 1) % TM) + 1;
      check("out_data", out_data, exp_q[0]);
      check("out_idx", SLICE_W'(out_idx), SLICE_W'(TM - rem));
      check("out_last", SLICE_W'(out_last), SLICE_W'(rem == 1));
    end
    rise = acc_done && !m_acc_q;
    drop = 1'b0;
    if (mv && out_ready) void'(exp_q.pop_front());
    if (rise) begin
      held = (exp_q.size() + TM - 1) / TM;
      if (held < CAP) begin
        for (int i = 0; i < TM; i++) exp_q.push_back(in_data[i*SLICE_W +: SLICE_W]);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_overrun = 1'b1;
    else if (clr_overrun) m_overrun = 1'b0;
    m_acc_q = acc_done;
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    acc_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst out_valid", SLICE_W'(out_valid), '0);
    check("rst out_data", out_data, '0);
    check("rst out_idx", SLICE_W'(out_idx), '0);
    check("rst out_last", SLICE_W'(out_last), '0);
    check("rst busy", SLICE_W'(busy), '0);
    check("rst overrun", SLICE_W'(overrun), '0);
    exp_q.delete();
    m_overrun = 1'b0;
    m_acc_q = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic pulse(int hi);
    acc_done = 1'b1;
    run(hi);
    acc_done = 1'b0;
  endtask

  initial begin
    logic [SLICE_W-1:0] sa, sb;
    sa = {(SLICE_W/4){4'hA}};
    sb = {(SLICE_W/4){4'hB}};

    apply_reset();
    run(3);

    // 1: basic two-slice stream, ready always high
    in_data = {sb, sa};
    out_ready = 1'b1;
    run(7);
    pulse(1);
    run(4);

    // 2: stall slice 0 for 5 cycles
    out_ready = 1'b0;
    pulse(1);
    run(5);
    out_ready = 1'b1;
    run(4);

    // 3: acc_done held high for 20 cycles gives one capture
    in_data = rand_vec();
    pulse(20);
    run(3);

    // 4: second rise while slice 0 stalled, then clear overrun
    out_ready = 1'b0;
    in_data = rand_vec();
    pulse(1);
    run(1);
    in_data = rand_vec();
    pulse(1);
    run(3);
    out_ready = 1'b1;
    run(6);
    clr_overrun = 1'b1;
    run(1);
    clr_overrun = 1'b0;
    run(2);

    // 4b: third rise while two results are held
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = rand_vec();
      pulse(1);
      run(1);
    end
    out_ready = 1'b1;
    run(8);
    clr_overrun = 1'b1;
    run(1);
    clr_overrun = 1'b0;

    // 5: rise on the final handshake keeps the stream unbroken
    in_data = rand_vec();
    pulse(1);
    run(1);
    in_data = rand_vec();
    pulse(1);
    run(4);

    // 6: reset after slice 0 accepted; nothing resumes after release
    in_data = rand_vec();
    pulse(1);
    run(1);
    apply_reset();
    run(5);

    // random phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) acc_done = ~acc_done;
      out_ready   = ($urandom_range(0, 9) < 7);
      clr_overrun = ($urandom_range(0, 15) == 0);
      in_data     = rand_vec();
      if (c == 1500) apply_reset();
      cycle();
    end
    acc_done = 1'b0;
    clr_overrun = 1'b0;
    out_ready = 1'b1;
    run(10);
    check("drained", SLICE_W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
